// File: rtl/pipemem_mmio.sv
// MEM stage of the pipelined CPU: word-addressed data RAM with byte/half/word
// access, sign/zero extension, misalignment detection and memory-mapped I/O
// (double-flopped input ports, registered output ports). Loads take one stall
// cycle because the RAM read is registered; stores complete in the accept cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready; stores complete here, loads are accepted and stall
// S_LD_WAIT | registered read word available; load completes (m_done)
module pipemem_mmio #(
    parameter int DATA_W     = 32,
    parameter int RAM_AW     = 5,
    parameter int IO_SEL_BIT = 7,
    parameter int NUM_IN     = 2,
    parameter int NUM_OUT    = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       m_valid,
    input  logic                       m_wmem,
    input  logic                       m_rmem,
    input  logic [1:0]                 m_size,
    input  logic                       m_unsign,
    input  logic [31:0]                m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    output logic                       m_stall,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_done,
    output logic                       m_err,
    input  logic [DATA_W*NUM_IN-1:0]   in_port,
    output logic [DATA_W*NUM_OUT-1:0]  out_port
);

    localparam int DEPTH = 2 ** RAM_AW;
    localparam int K_W   = IO_SEL_BIT - 2;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_LD_WAIT = 1'b1;

    logic [DATA_W-1:0]         ram_mem [DEPTH];

    logic [0:0]                state_q, state_d;
    logic [DATA_W*NUM_IN-1:0]  sync1_q, sync1_d;
    logic [DATA_W*NUM_IN-1:0]  sync2_q, sync2_d;
    logic [DATA_W*NUM_OUT-1:0] out_q, out_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic [DATA_W-1:0]         ld_word_q, ld_word_d;
    logic [1:0]                ld_lane_q, ld_lane_d;
    logic [1:0]                ld_size_q, ld_size_d;
    logic                      ld_unsign_q, ld_unsign_d;
    logic                      ld_err_q, ld_err_d;

    logic                      is_io;
    logic [K_W-1:0]            io_k;
    logic [RAM_AW-1:0]         ram_idx;
    logic                      acc_err;
    logic                      accept, st_acc, ld_acc, ld_fin;
    logic                      ram_we, out_we;
    logic [3:0]                be;
    logic [DATA_W-1:0]         wdata_rep;
    logic [DATA_W-1:0]         io_rd;
    logic [7:0]                ld_b;
    logic [15:0]               ld_h;
    logic [DATA_W-1:0]         ld_ext;

    // Address bits above the I/O select bit play no part in decoding.
    logic unused_addr;
    assign unused_addr = ^m_addr[31:IO_SEL_BIT+1];

    // Request decode: space select, legality, handshake qualifiers, write lanes.
    always_comb begin
        is_io   = m_addr[IO_SEL_BIT];
        io_k    = m_addr[IO_SEL_BIT-1:2];
        ram_idx = m_addr[RAM_AW+1:2];
        case (m_size)
            2'b00:   acc_err = is_io;
            2'b01:   acc_err = m_addr[0] | is_io;
            2'b10:   acc_err = (m_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
        accept = ~reset & (state_q == S_IDLE) & m_valid;
        st_acc = accept & m_wmem;
        ld_acc = accept & m_rmem & ~m_wmem;
        ld_fin = ~reset & (state_q == S_LD_WAIT);
        ram_we = st_acc & ~acc_err & ~is_io;
        out_we = st_acc & ~acc_err & is_io & (int'(io_k) < NUM_OUT);
        case (m_size)
            2'b00: begin
                be        = 4'b0001 << m_addr[1:0];
                wdata_rep = {4{m_wdata[7:0]}};
            end
            2'b01: begin
                be        = m_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{m_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = m_wdata;
            end
        endcase
    end

    // Input port select; unmapped ports read as zero.
    always_comb begin
        io_rd = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(io_k) == i) io_rd = sync2_q[DATA_W*i +: DATA_W];
        end
    end

    // Lane extraction and extension of the registered load word.
    always_comb begin
        ld_b = ld_word_q[{ld_lane_q, 3'b000} +: 8];
        ld_h = ld_word_q[{ld_lane_q[1], 4'b0000} +: 16];
        case (ld_size_q)
            2'b00:   ld_ext = {{24{~ld_unsign_q & ld_b[7]}}, ld_b};
            2'b01:   ld_ext = {{16{~ld_unsign_q & ld_h[15]}}, ld_h};
            default: ld_ext = ld_word_q;
        endcase
        if (ld_err_q) ld_ext = '0;
    end

    // Next-state: FSM, load capture, result hold, output ports, input synchronisers.
    always_comb begin
        state_d     = state_q;
        ld_word_d   = ld_word_q;
        ld_lane_d   = ld_lane_q;
        ld_size_d   = ld_size_q;
        ld_unsign_d = ld_unsign_q;
        ld_err_d    = ld_err_q;
        rdata_d     = rdata_q;
        out_d       = out_q;
        sync1_d     = in_port;
        sync2_d     = sync1_q;

        if (ld_acc) begin
            state_d     = S_LD_WAIT;
            ld_word_d   = is_io ? io_rd : ram_mem[ram_idx];
            ld_lane_d   = m_addr[1:0];
            ld_size_d   = m_size;
            ld_unsign_d = m_unsign;
            ld_err_d    = acc_err;
        end else if (state_q == S_LD_WAIT) begin
            state_d = S_IDLE;
        end

        if (ld_fin) begin
            rdata_d = ld_ext;
        end else if (st_acc & acc_err) begin
            rdata_d = '0;
        end

        for (int i = 0; i < NUM_OUT; i++) begin
            if (out_we && (int'(io_k) == i)) out_d[DATA_W*i +: DATA_W] = m_wdata;
        end
    end

    // Handshake outputs; m_rdata shows the completing load in its done cycle.
    always_comb begin
        m_stall  = ld_acc;
        m_done   = st_acc | ld_fin;
        m_err    = (st_acc & acc_err) | (ld_fin & ld_err_q);
        m_rdata  = rdata_d;
        out_port = out_q;
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            out_q       <= '0;
            rdata_q     <= '0;
            ld_word_q   <= '0;
            ld_lane_q   <= '0;
            ld_size_q   <= '0;
            ld_unsign_q <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            out_q       <= out_d;
            rdata_q     <= rdata_d;
            ld_word_q   <= ld_word_d;
            ld_lane_q   <= ld_lane_d;
            ld_size_q   <= ld_size_d;
            ld_unsign_q <= ld_unsign_d;
            ld_err_q    <= ld_err_d;
        end
    end

    // Data RAM: per-byte write enables, contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram_mem[ram_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_pipemem_mmio.sv
// Bench for pipemem_mmio: directed scenarios plus randomized accesses checked
// against a byte-array memory model with I/O port arrays.
module tb_pipemem_mmio;

    localparam int NI = 2;
    localparam int NO = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              m_valid, m_wmem, m_rmem, m_unsign;
    logic [1:0]        m_size;
    logic [31:0]       m_addr, m_wdata;
    logic              m_stall, m_done, m_err;
    logic [31:0]       m_rdata;
    logic [32*NI-1:0]  in_port;
    logic [32*NO-1:0]  out_port;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem_b [128];
    logic [31:0] in_m  [NI];
    logic [31:0] out_m [NO];
    logic [31:0] rdata_m;

    pipemem_mmio dut (
        .clock    (clock),
        .reset    (reset),
        .m_valid  (m_valid),
        .m_wmem   (m_wmem),
        .m_rmem   (m_rmem),
        .m_size   (m_size),
        .m_unsign (m_unsign),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_stall  (m_stall),
        .m_rdata  (m_rdata),
        .m_done   (m_done),
        .m_err    (m_err),
        .in_port  (in_port),
        .out_port (out_port)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b0;
        if (sz == 2'd1 && a[0]) return 1'b0;
        if (sz == 2'd2 && a[1:0] != 2'b00) return 1'b0;
        if (a[7] && sz != 2'd2) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [31:0] a);
        logic [31:0] v;
        int n, base, k;
        if (!legal(sz, a)) return 32'h0;
        if (a[7]) begin
            k = int'(a[6:2]);
            return (k < NI) ? in_m[k] : 32'h0;
        end
        n = 1 << sz;
        base = int'(a[6:0]);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_b[base + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n, base, k;
        if (!legal(sz, a)) begin
            rdata_m = 32'h0;
            return;
        end
        if (a[7]) begin
            k = int'(a[6:2]);
            if (k < NO) out_m[k] = d;
        end else begin
            n = 1 << sz;
            base = int'(a[6:0]);
            for (int i = 0; i < n; i++) mem_b[base + i] = d[8*i +: 8];
        end
    endtask

    task automatic check_ports(input string tag);
        for (int i = 0; i < NO; i++) chk($sformatf("%s out_port[%0d]", tag, i), out_port[32*i +: 32], out_m[i]);
    endtask

    task automatic set_in(input int k, input logic [31:0] v);
        in_m[k] = v;
        in_port[32*k +: 32] = v;
    endtask

    task automatic idle(input int n);
        m_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic do_op(input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
        bit exp_err;
        logic [31:0] exp_rd;
        exp_err  = !legal(sz, a);
        m_valid  = 1'b1;
        m_wmem   = st;
        m_rmem   = st ? 1'($urandom_range(0, 1)) : 1'b1;
        m_size   = sz;
        m_unsign = uns;
        m_addr   = a;
        m_wdata  = d;
        if (st) begin
            @(negedge clock);
            chk({tag, " st done"}, m_done, 1);
            chk({tag, " st stall"}, m_stall, 0);
            chk({tag, " st err"}, m_err, exp_err);
            if (exp_err) chk({tag, " st err rdata"}, m_rdata, 0);
            model_store(sz, a, d);
            @(posedge clock);
            #1;
            m_valid = 1'b0;
            check_ports(tag);
        end else begin
            exp_rd = model_load(sz, uns, a);
            @(negedge clock);
            chk({tag, " ld stall"}, m_stall, 1);
            chk({tag, " ld early done"}, m_done, 0);
            @(negedge clock);
            chk({tag, " ld stall2"}, m_stall, 0);
            chk({tag, " ld done"}, m_done, 1);
            chk({tag, " ld err"}, m_err, exp_err);
            chk({tag, " ld rdata"}, m_rdata, exp_rd);
            rdata_m = exp_rd;
            @(posedge clock);
            #1;
            m_valid = 1'b0;
        end
        #1;
        chk({tag, " rdata hold"}, m_rdata, rdata_m);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0]  sz;
        bit          st, uns, io;

        reset = 1'b1; m_valid = 1'b1; m_wmem = 1'b0; m_rmem = 1'b1;
        m_size = 2'd2; m_unsign = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
        in_port = '0;
        for (int i = 0; i < NI; i++) in_m[i] = 32'h0;
        for (int i = 0; i < NO; i++) out_m[i] = 32'h0;
        rdata_m = 32'h0;

        // Reset values, load request ignored while reset is high.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset stall", m_stall, 0);
        chk("reset done", m_done, 0);
        chk("reset rdata", m_rdata, 0);
        check_ports("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_valid = 1'b0;

        // Fill the whole RAM so later loads compare against known data.
        for (int w = 0; w < 32; w++) do_op(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, "preload");

        // Load requested across reset release: only accepted once reset is low.
        reset = 1'b1;
        m_valid = 1'b1; m_wmem = 1'b0; m_rmem = 1'b1; m_size = 2'd2; m_addr = 32'h0;
        @(negedge clock);
        chk("rst ld stall", m_stall, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NO; i++) out_m[i] = 32'h0;
        rdata_m = 32'h0;
        do_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "post-reset lw 0");

        // Sub-word access to a known word.
        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h8765_4321, "sw 0x10");
        do_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, "lb 0x11");
        do_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "lbu 0x13");
        do_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lb 0x13");
        do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "lh 0x12");
        do_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "lhu 0x12");
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw 0x10");
        do_op(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AA, "sb 0x12");
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw 0x10 after sb");
        chk("sb merge literal", rdata_m, 32'h87AA_4321);
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_1F10, 32'h0, "lw alias 0x1F10");

        // Memory-mapped I/O.
        do_op(1'b1, 2'd2, 1'b0, 32'h84, 32'h0000_1234, "sw 0x84");
        chk("out_port[1] literal", out_port[63:32], 32'h0000_1234);
        set_in(1, 32'h0000_0055);
        idle(3);
        do_op(1'b0, 2'd2, 1'b0, 32'h84, 32'h0, "lw 0x84");
        do_op(1'b1, 2'd2, 1'b0, 32'h8C, 32'hDEAD_BEEF, "sw 0x8C");
        do_op(1'b0, 2'd2, 1'b0, 32'h88, 32'h0, "lw 0x88 unmapped");

        // Illegal accesses.
        do_op(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, "lw 0x02");
        do_op(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, "lh 0x01");
        do_op(1'b1, 2'd0, 1'b0, 32'h80, 32'h0000_0077, "sb 0x80");
        do_op(1'b1, 2'd2, 1'b0, 32'h06, 32'hFFFF_FFFF, "sw 0x06");
        do_op(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, "size11 ld");
        do_op(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, "lw 0x04 intact");

        // Reset during LD_WAIT aborts the load but keeps RAM.
        m_valid = 1'b1; m_wmem = 1'b0; m_rmem = 1'b1; m_size = 2'd2; m_unsign = 1'b0;
        m_addr = 32'h10;
        @(negedge clock);
        chk("abort ld stall", m_stall, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("abort done", m_done, 0);
        chk("abort stall", m_stall, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_valid = 1'b0;
        for (int i = 0; i < NO; i++) out_m[i] = 32'h0;
        rdata_m = 32'h0;
        @(negedge clock);
        chk("abort rdata", m_rdata, 0);
        chk("abort stall2", m_stall, 0);
        chk("abort done2", m_done, 0);
        check_ports("abort");
        @(posedge clock);
        #1;
        idle(2);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw 0x10 after abort");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) begin
                for (int k = 0; k < NI; k++) set_in(k, $urandom);
                idle(3);
            end
            st  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            io  = ($urandom_range(0, 3) == 0);
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = $urandom;
            a[7] = io;
            if (io) a[6:2] = 5'($urandom_range(0, 4));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            d = $urandom;
            do_op(st, sz, uns, a, d, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
